// File: rtl/fp16_mul_arbiter.sv
// Two-port round-robin front end sharing one MUL_LAT-cycle fp16 multiplier, with credit-managed
// per-port response FIFOs. Defining FP16_ARB_STATS_EN adds saturating per-port grant counters.
module fp16_mul_arbiter #(
    parameter int MUL_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        req_valid_0,
    output logic        req_ready_0,
    input  logic [15:0] req_A_0,
    input  logic [15:0] req_B_0,
    input  logic        req_valid_1,
    output logic        req_ready_1,
    input  logic [15:0] req_A_1,
    input  logic [15:0] req_B_1,
    output logic        rsp_valid_0,
    input  logic        rsp_ready_0,
    output logic [15:0] rsp_data_0,
    output logic        rsp_valid_1,
    input  logic        rsp_ready_1,
    output logic [15:0] rsp_data_1,
    output logic [15:0] mul_A,
    output logic [15:0] mul_B,
    input  logic [15:0] mul_out
`ifdef FP16_ARB_STATS_EN
    ,
    output logic [15:0] grant_cnt_0,
    output logic [15:0] grant_cnt_1
`endif
);

    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]      r_credit [2];
    logic [CW-1:0]      r_count  [2];
    logic [PW-1:0]      r_wrPtr  [2];
    logic [PW-1:0]      r_rdPtr  [2];
    logic [15:0]        r_fifo   [2][RSP_DEPTH];
    logic               r_lastGrant;
    logic [MUL_LAT-1:0] r_tagValid;
    logic [MUL_LAT-1:0] r_tagPort;

    logic [1:0] w_reqValid;
    logic [1:0] w_rspReady;
    logic [1:0] w_creditOk;
    logic [1:0] w_elig;
    logic [1:0] w_ready;
    logic [1:0] w_issue;
    logic [1:0] w_write;
    logic [1:0] w_rspValid;
    logic [1:0] w_pop;

    // Ready is offered from credit and the other port's eligibility only, never from our own valid.
    always_comb begin
        w_reqValid = {req_valid_1, req_valid_0};
        w_rspReady = {rsp_ready_1, rsp_ready_0};
        w_creditOk = '0;
        w_rspValid = '0;
        w_write    = '0;
        for (int p = 0; p < 2; p++) begin
            w_creditOk[p] = (r_credit[p] < CW'(RSP_DEPTH));
            w_rspValid[p] = (r_count[p] != '0);
            w_write[p]    = r_tagValid[MUL_LAT-1] && (r_tagPort[MUL_LAT-1] == p[0]);
        end
        w_elig     = w_reqValid & w_creditOk;
        w_ready[0] = RESETn & w_creditOk[0] & (~w_elig[1] | r_lastGrant);
        w_ready[1] = RESETn & w_creditOk[1] & (~w_elig[0] | ~r_lastGrant);
        w_issue    = w_ready & w_reqValid;
        w_pop      = w_rspValid & w_rspReady;
        mul_A      = '0;
        mul_B      = '0;
        if (w_issue[0]) begin
            mul_A = req_A_0;
            mul_B = req_B_0;
        end else if (w_issue[1]) begin
            mul_A = req_A_1;
            mul_B = req_B_1;
        end
    end

    assign req_ready_0 = w_ready[0];
    assign req_ready_1 = w_ready[1];
    assign rsp_valid_0 = w_rspValid[0];
    assign rsp_valid_1 = w_rspValid[1];
    assign rsp_data_0  = w_rspValid[0] ? r_fifo[0][r_rdPtr[0]] : '0;
    assign rsp_data_1  = w_rspValid[1] ? r_fifo[1][r_rdPtr[1]] : '0;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_tagValid  <= '0;
            r_tagPort   <= '0;
            r_lastGrant <= 1'b1;
        end else begin
            r_tagValid[0] <= |w_issue;
            r_tagPort[0]  <= w_issue[1];
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagPort[i]  <= r_tagPort[i-1];
            end
            if (|w_issue) begin
                r_lastGrant <= ~r_lastGrant;
            end
        end
    end

    // Credit covers in-flight plus queued results, so a tagged write always finds space.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int p = 0; p < 2; p++) begin
                r_credit[p] <= '0;
                r_count[p]  <= '0;
                r_wrPtr[p]  <= '0;
                r_rdPtr[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_credit[p] <= r_credit[p] + CW'(w_issue[p]) - CW'(w_pop[p]);
                r_count[p]  <= r_count[p] + CW'(w_write[p]) - CW'(w_pop[p]);
                if (w_write[p]) begin
                    r_wrPtr[p] <= r_wrPtr[p] + PW'(1);
                end
                if (w_pop[p]) begin
                    r_rdPtr[p] <= r_rdPtr[p] + PW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int p = 0; p < 2; p++) begin
            if (w_write[p]) begin
                r_fifo[p][r_wrPtr[p]] <= mul_out;
            end
        end
    end

`ifdef FP16_ARB_STATS_EN
    logic [15:0] r_grantCnt [2];

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_grantCnt[0] <= '0;
            r_grantCnt[1] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (w_issue[p] && (r_grantCnt[p] != 16'hFFFF)) begin
                    r_grantCnt[p] <= r_grantCnt[p] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt_0 = r_grantCnt[0];
    assign grant_cnt_1 = r_grantCnt[1];
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Scoreboard bench for fp16_mul_arbiter: a behavioural fp16 multiplier sits on the mul port, a
// negedge monitor pops expected products queued at each request transfer.
module tb_fp16_mul_arbiter;

    localparam int MUL_LAT   = 2;
    localparam int RSP_DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        req_valid_0, req_ready_0, req_valid_1, req_ready_1;
    logic [15:0] req_A_0, req_B_0, req_A_1, req_B_1;
    logic        rsp_valid_0, rsp_ready_0, rsp_valid_1, rsp_ready_1;
    logic [15:0] rsp_data_0, rsp_data_1;
    logic [15:0] mul_A, mul_B, mul_out;
`ifdef FP16_ARB_STATS_EN
    logic [15:0] grantCnt0, grantCnt1;
`endif

    fp16_mul_arbiter #(.MUL_LAT(MUL_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_A_0(req_A_0), .req_B_0(req_B_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_A_1(req_A_1), .req_B_1(req_B_1),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_data_0(rsp_data_0),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1),
        .mul_A(mul_A), .mul_B(mul_B), .mul_out(mul_out)
`ifdef FP16_ARB_STATS_EN
        , .grant_cnt_0(grantCnt0), .grant_cnt_1(grantCnt1)
`endif
    );

    always #5 CLK = ~CLK;

    // Directed vectors: operands and hand-computed exact fp16 products.
    logic [15:0] vecA [8] = '{16'h3C00, 16'h4000, 16'h3E00, 16'h3E00, 16'hC000, 16'h4200, 16'h4500, 16'h0000};
    logic [15:0] vecB [8] = '{16'h4000, 16'h4000, 16'h4000, 16'h3E00, 16'h3800, 16'h4200, 16'h4000, 16'h4400};
    logic [15:0] vecP [8] = '{16'h4000, 16'h4400, 16'h4200, 16'h4080, 16'hBC00, 16'h4880, 16'h4900, 16'h0000};

    int checksTotal = 0;
    int checksPassed = 0;
    int cycleCount = 0;
    logic [15:0] sbQ0 [$];
    logic [15:0] sbQ1 [$];
    int grantLog [$];
    int grantCyc [$];
    int idx [2];
    int limit [2];
    int sent [2];
    int issueCnt [2];
    logic [15:0] mulPipe [MUL_LAT];

    function automatic logic [15:0] fp16Mul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] m;
        logic [9:0]  f;
        s = a[15] ^ b[15];
        if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        m = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
        if (m[21]) begin
            e = e + 1;
            f = m[20:11];
        end else begin
            f = m[19:10];
        end
        return {s, e[4:0], f};
    endfunction

    always @(posedge CLK) begin
        mulPipe[0] <= fp16Mul(mul_A, mul_B);
        for (int i = 1; i < MUL_LAT; i++) mulPipe[i] <= mulPipe[i-1];
        cycleCount <= cycleCount + 1;
    end
    assign mul_out = mulPipe[MUL_LAT-1];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Monitor: pops the scoreboard on every response handshake and guards against FIFO overflow.
    always @(negedge CLK) begin
        if (RESETn) begin
            if (rsp_valid_0 && rsp_ready_0) begin
                if (sbQ0.size() == 0) checkOutput("rsp0 unexpected", {31'd0, rsp_valid_0}, 32'd0);
                else checkOutput("rsp0 data", {16'd0, rsp_data_0}, {16'd0, sbQ0.pop_front()});
            end
            if (rsp_valid_1 && rsp_ready_1) begin
                if (sbQ1.size() == 0) checkOutput("rsp1 unexpected", {31'd0, rsp_valid_1}, 32'd0);
                else checkOutput("rsp1 data", {16'd0, rsp_data_1}, {16'd0, sbQ1.pop_front()});
            end
            for (int p = 0; p < 2; p++) begin
                if (dut.w_write[p] && !dut.w_pop[p] && (dut.r_count[p] >= RSP_DEPTH))
                    checkOutput("fifo overflow", 32'(dut.r_count[p]), RSP_DEPTH - 1);
            end
        end
    end

    task automatic setPort(input int p, input logic on);
        if (p == 0) begin
            req_valid_0 = on;
            req_A_0 = vecA[idx[0]];
            req_B_0 = vecB[idx[0]];
        end else begin
            req_valid_1 = on;
            req_A_1 = vecA[idx[1]];
            req_B_1 = vecB[idx[1]];
        end
    endtask

    task automatic clearStats();
        issueCnt[0] = 0;
        issueCnt[1] = 0;
        sent[0] = 0;
        sent[1] = 0;
        grantLog.delete();
        grantCyc.delete();
    endtask

    task automatic doReset();
        RESETn = 1'b0;
        req_valid_0 = 1'b0;
        req_valid_1 = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RESETn = 1'b1;
        clearStats();
    endtask

    // Runs n cycles; each observed request transfer queues its expected product and advances the port.
    task automatic applyStimulus(input int n);
        logic [1:0] fired;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            fired = {req_valid_1 & req_ready_1, req_valid_0 & req_ready_0};
            if (fired == 2'b00) begin
                checkOutput("mulA idle", {16'd0, mul_A}, 32'd0);
            end
            for (int p = 0; p < 2; p++) begin
                if (fired[p]) begin
                    checkOutput("mulA granted", {16'd0, mul_A}, {16'd0, vecA[idx[p]]});
                    checkOutput("mulB granted", {16'd0, mul_B}, {16'd0, vecB[idx[p]]});
                    if (p == 0) sbQ0.push_back(vecP[idx[p]]);
                    else sbQ1.push_back(vecP[idx[p]]);
                    issueCnt[p]++;
                    grantLog.push_back(p);
                    grantCyc.push_back(cycleCount);
                end
            end
            @(posedge CLK);
            #1;
            for (int p = 0; p < 2; p++) begin
                if (fired[p]) begin
                    sent[p]++;
                    idx[p] = (idx[p] + 1) % 8;
                    setPort(p, sent[p] < limit[p]);
                end
            end
        end
    endtask

    task automatic waitDrain(input string name);
        for (int c = 0; c < 100; c++) begin
            if (sbQ0.size() == 0 && sbQ1.size() == 0) break;
            @(negedge CLK);
        end
        checkOutput(name, sbQ0.size() + sbQ1.size(), 32'd0);
        sbQ0.delete();
        sbQ1.delete();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int seen;
        RESETn = 1'b0;
        req_valid_0 = 1'b1;
        req_A_0 = 16'h3C00;
        req_B_0 = 16'h4000;
        req_valid_1 = 1'b1;
        req_A_1 = 16'h4000;
        req_B_1 = 16'h4000;
        rsp_ready_0 = 1'b1;
        rsp_ready_1 = 1'b1;
        #12;
        checkOutput("reset req_ready_0", {31'd0, req_ready_0}, 32'd0);
        checkOutput("reset req_ready_1", {31'd0, req_ready_1}, 32'd0);
        checkOutput("reset rsp_valid_0", {31'd0, rsp_valid_0}, 32'd0);
        checkOutput("reset rsp_valid_1", {31'd0, rsp_valid_1}, 32'd0);
        checkOutput("reset rsp_data_0", {16'd0, rsp_data_0}, 32'd0);
        checkOutput("reset mul_A", {16'd0, mul_A}, 32'd0);
        checkOutput("reset mul_B", {16'd0, mul_B}, 32'd0);

        $display("[TB] single-port latency");
        doReset();
        idx[0] = 0;
        limit[0] = 1;
        setPort(0, 1'b1);
        applyStimulus(1);
        checkOutput("single issues", issueCnt[0], 32'd1);
        for (int k = 1; k <= 3; k++) begin
            @(negedge CLK);
            checkOutput("single rsp_valid latency", {31'd0, rsp_valid_0}, (k == 3) ? 32'd1 : 32'd0);
        end
        waitDrain("single drain");

        $display("[TB] contention");
        doReset();
        idx[0] = 0;
        idx[1] = 4;
        limit[0] = 6;
        limit[1] = 6;
        setPort(0, 1'b1);
        setPort(1, 1'b1);
        applyStimulus(14);
        checkOutput("contention issues p0", issueCnt[0], 32'd6);
        checkOutput("contention issues p1", issueCnt[1], 32'd6);
        for (int i = 0; i < grantLog.size(); i++) begin
            checkOutput("contention grant port", grantLog[i], i % 2);
            checkOutput("contention grant cycle", grantCyc[i] - grantCyc[0], i);
        end
        waitDrain("contention drain");

        $display("[TB] backpressure");
        doReset();
        rsp_ready_1 = 1'b0;
        idx[1] = 0;
        limit[1] = 100;
        setPort(1, 1'b1);
        applyStimulus(10);
        checkOutput("backpressure issues", issueCnt[1], 32'd4);
        checkOutput("backpressure ready held", {31'd0, req_ready_1}, 32'd0);
        rsp_ready_1 = 1'b1;
        @(posedge CLK);
        #1;
        rsp_ready_1 = 1'b0;
        clearStats();
        limit[1] = 100;
        applyStimulus(8);
        checkOutput("backpressure reissue", issueCnt[1], 32'd1);
        setPort(1, 1'b0);
        rsp_ready_1 = 1'b1;
        waitDrain("backpressure drain");

        $display("[TB] overlap");
        doReset();
        rsp_ready_0 = 1'b0;
        idx[0] = 0;
        limit[0] = 100;
        setPort(0, 1'b1);
        applyStimulus(6);
        checkOutput("overlap fill p0", issueCnt[0], 32'd4);
        clearStats();
        limit[0] = 100;
        limit[1] = 100;
        idx[1] = 2;
        setPort(1, 1'b1);
        applyStimulus(8);
        checkOutput("overlap p0 starved", issueCnt[0], 32'd0);
        checkOutput("overlap p1 every cycle", issueCnt[1], 32'd8);
        setPort(1, 1'b0);
        rsp_ready_0 = 1'b1;
        applyStimulus(4);
        setPort(0, 1'b0);
        waitDrain("overlap drain");

        $display("[TB] reset mid-operation");
        doReset();
        idx[0] = 0;
        limit[0] = 2;
        setPort(0, 1'b1);
        applyStimulus(2);
        RESETn = 1'b0;
        #3;
        RESETn = 1'b1;
        sbQ0.delete();
        clearStats();
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            if (rsp_valid_0 || rsp_valid_1) seen++;
        end
        checkOutput("reset discards in-flight", seen, 32'd0);
        @(posedge CLK);
        #1;
        rsp_ready_0 = 1'b0;
        idx[0] = 0;
        limit[0] = 100;
        setPort(0, 1'b1);
        applyStimulus(8);
        checkOutput("reset credit cleared", issueCnt[0], 32'd4);
        setPort(0, 1'b0);
        rsp_ready_0 = 1'b1;
        waitDrain("reset drain");

`ifdef FP16_ARB_STATS_EN
        $display("[TB] grant counter saturation");
        doReset();
        checkOutput("stats reset", {16'd0, grantCnt0}, 32'd0);
        idx[0] = 0;
        limit[0] = 70000;
        setPort(0, 1'b1);
        applyStimulus(70010);
        checkOutput("stats issues", issueCnt[0], 32'd70000);
        checkOutput("stats grant_cnt_0", {16'd0, grantCnt0}, 32'h0000FFFF);
        checkOutput("stats grant_cnt_1", {16'd0, grantCnt1}, 32'd0);
        waitDrain("stats drain");
`endif

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
